sd_traffic_gen: RTL
===================

Name: sd_traffic_gen

Overview:
- Parametrised traffic generator and checker for card_driver; it sits between card_driver's command/data/result interface and a status sink (UART FIFO, LEDs).
- Issues write, read or alternating write-then-read bursts with a selectable burst length.
- Generates deterministic write data and verifies read-back data byte by byte, counting mismatches.
- Emits one status character per accepted command and a final summary.

Parameters:
- ADDR_W, 32, width of WR_ADDR/RD_ADDR and the address counter.
- LEN_W, 32, width of WR_LENGTH/RD_LENGTH.
- CNT_W, 16, width of ERR_CNT and BURST_CNT; both saturate.
- NUM_BURSTS, 0, bursts per run; 0 = run until START deasserts.
- SEED, 8'h41, initial pattern value ("A").

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- START  in  1  level; run while high.
- MODE  in  2  0 = write-only, 1 = read-only, 2 = write-then-read-verify, 3 = reserved (treated as 0).
- LEN_SEL  in  3  burst length index {1,2,5,10,100,1000,10000,100000}.
- PATTERN_SEL  in  1  0 = counter, 1 = LFSR (only with the macro).
- DRV_BUSY  in  1  backpressure from the result/status FIFO almost-full.
- WR_STB  out  1  write command request.
- WR_ADDR  out  ADDR_W  write start address.
- WR_LENGTH  out  LEN_W  write burst length.
- WR_ACK  in  1  one-cycle write command acceptance.
- WD_STB  out  1  write data valid.
- WD_DATA  out  8  write data byte.
- WD_ACK  in  1  write data byte consumed.
- RD_STB  out  1  read command request.
- RD_ADDR  out  ADDR_W  read start address.
- RD_LENGTH  out  LEN_W  read burst length.
- RD_ACK  in  1  one-cycle read command acceptance.
- RES_STB  in  1  read result byte valid.
- RES_DEBUG  in  1  result byte is a debug byte; not checked.
- RES_DATA  in  8  read result byte.
- RES_BUSY  out  1  result backpressure = DRV_BUSY.
- STAT_STB  out  1  one-cycle status character strobe.
- STAT_DAT  out  8  status character.
- RUNNING  out  1  FSM not in IDLE/DONE.
- DONE  out  1  level; run completed.
- ERR_CNT  out  CNT_W  mismatching result bytes.
- BURST_CNT  out  CNT_W  completed bursts.

Behaviour:
- Clock and reset: single clock CLK; RST is asynchronous, active-high.
- Reset values:
  - All strobes 0; WD_STB 0.
  - Both addresses 0; both lengths 0.
  - WD_DATA = SEED.
  - STAT_DAT 0; RUNNING 0; DONE 0; ERR_CNT 0; BURST_CNT 0.
  - FSM in IDLE.
- Reset mid-operation aborts everything immediately; no flush.
- FSM states:
  - IDLE: on a START rising edge, latch MODE, LEN_SEL and PATTERN_SEL; clear the counters and DONE; reseed both pattern generators; go to ISSUE_WR (MODE 0/2/3) or ISSUE_RD (MODE 1).
  - ISSUE_WR: WR_STB = 1, WR_LENGTH = burst_len; hold until WR_ACK. On WR_ACK drop WR_STB the next cycle, pulse STAT "w", go to WAIT.
  - ISSUE_RD: same as ISSUE_WR with RD_*; STAT "r".
  - WAIT: stay while DRV_BUSY = 1. Then MODE 2 after a write goes to ISSUE_RD at the same address; otherwise go to ADVANCE.
  - ADVANCE: WR_ADDR and RD_ADDR += burst_len, modulo 2^ADDR_W. BURST_CNT++ (saturating). If NUM_BURSTS != 0 and BURST_CNT+1 == NUM_BURSTS, or START = 0, go to DONE; else return to the first ISSUE state.
  - DONE: DONE = 1; pulse STAT "P" if ERR_CNT == 0, else "F". Return to IDLE when START = 0.
- Command handshake: a strobe never drops before its ACK. An ACK arriving in a state that is not issuing is ignored.
- Write data:
  - WD_STB = 1 whenever RUNNING.
  - On WD_ACK, WD_DATA advances to the next pattern value in the same cycle's register update.
  - Data continues across burst boundaries; it is not reset per burst.
- Read check:
  - Active in MODE 1/2 only.
  - Each RES_STB && !RES_DEBUG byte is compared with the expected generator, which then advances.
  - On mismatch, ERR_CNT++ (saturating at all-ones).
  - The first mismatch of each burst also pulses STAT "E".
- STAT collisions: if two STAT events coincide, the priority is E > w/r > P/F. The lost event is dropped, and only its STAT character is dropped.
- Mid-run START deassertion: the current burst completes; there is no abort.

Optional Feature:
- Macro LFSR_PATTERN_EN.
- Defined: PATTERN_SEL = 1 selects an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded with SEED. Seed 0 is forced to 8'h01.
- Not defined: the LFSR is not synthesised; PATTERN_SEL is ignored; the counter pattern (+1 per byte, wrapping 8'hFF→8'h00) is always used.

Decomposition:
- Shared package/include sd_test_pkg holds:
  - MODE encodings.
  - The burst length table.
  - FSM state encodings.
  - Status character constants "w" "r" "E" "P" "F".
- Natural sub-module sd_pattern_gen (inputs CLK, RST, SEED_LD, ADV, SEL; output 8-bit value), instantiated twice: once for the write generator and once for the expected-data generator.

Test Plan:
- MODE 0, LEN_SEL 3, NUM_BURSTS 3, driver model ACKs after 4 cycles: WR_ADDR sequence 0, 10, 20; three "w" then "P"; BURST_CNT = 3; DONE = 1.
- MODE 2, LEN_SEL 1, loopback memory model: write at 0, then read at 0, then advance to 2. WD_DATA starts 8'h41; ERR_CNT = 0; STAT sequence "w","r","w","r",...
- MODE 1, with one corrupted result byte (8'h43 returned as 8'h00) and one RES_DEBUG byte: ERR_CNT = 1; a single "E"; the debug byte is not compared; final "F".
- DRV_BUSY held high for 50 cycles after WR_ACK: no new strobe during those cycles; ISSUE resumes 1 cycle after DRV_BUSY falls.
- RST asserted while WR_STB = 1: all outputs return to reset values asynchronously; a later START begins again at address 0 with WD_DATA = 8'h41.
- With LFSR_PATTERN_EN and PATTERN_SEL = 1: the first five WD_DATA values match the reference LFSR sequence from 8'h41. Without the macro: the values are 41, 42, 43, 44, 45.

Source files
------------

// File: rtl/sd_test_pkg.sv
// ============================================================================
// Module      : sd_test_pkg
// Description : Shared encodings for the card_driver traffic generator:
//               modes, FSM states, burst length table, status characters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd_test_pkg;

  localparam logic [1:0] c_mode_wr   = 2'd0;
  localparam logic [1:0] c_mode_rd   = 2'd1;
  localparam logic [1:0] c_mode_wrv  = 2'd2;
  localparam logic [1:0] c_mode_rsvd = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE_WR = 3'd1,
    ST_ISSUE_RD = 3'd2,
    ST_WAIT     = 3'd3,
    ST_ADVANCE  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [7:0] c_stat_wr   = 8'h77;  // "w"
  localparam logic [7:0] c_stat_rd   = 8'h72;  // "r"
  localparam logic [7:0] c_stat_err  = 8'h45;  // "E"
  localparam logic [7:0] c_stat_pass = 8'h50;  // "P"
  localparam logic [7:0] c_stat_fail = 8'h46;  // "F"

  function automatic logic [31:0] burst_len(input logic [2:0] sel);
    case (sel)
      3'd0:    burst_len = 32'd1;
      3'd1:    burst_len = 32'd2;
      3'd2:    burst_len = 32'd5;
      3'd3:    burst_len = 32'd10;
      3'd4:    burst_len = 32'd100;
      3'd5:    burst_len = 32'd1000;
      3'd6:    burst_len = 32'd10000;
      default: burst_len = 32'd100000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_pattern_gen.sv
// ============================================================================
// Module      : sd_pattern_gen
// Description : 8-bit data pattern source: +1 counter, or an x^8+x^6+x^5+x^4+1
//               Fibonacci LFSR when built with LFSR_PATTERN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_pattern_gen #(
  parameter logic [7:0] SEED = 8'h41
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SEED_LD,
  input  logic       ADV,
  input  logic       SEL,
  output logic [7:0] VALUE
);

  logic [7:0] r_value;
  logic [7:0] w_seed;
  logic [7:0] w_next;

`ifdef LFSR_PATTERN_EN
  logic w_fb;
  assign w_fb   = r_value[7] ^ r_value[5] ^ r_value[4] ^ r_value[3];
  // An all-zero LFSR would lock up, so a zero seed is bumped to 1.
  assign w_seed = (SEL && (SEED == 8'h00)) ? 8'h01 : SEED;
  assign w_next = SEL ? {r_value[6:0], w_fb} : (r_value + 8'd1);
`else
  logic w_unused_sel;
  assign w_unused_sel = SEL;
  assign w_seed       = SEED;
  assign w_next       = r_value + 8'd1;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_value <= SEED;
    end else if (SEED_LD) begin
      r_value <= w_seed;
    end else if (ADV) begin
      r_value <= w_next;
    end
  end

  assign VALUE = r_value;

endmodule

`default_nettype wire

// File: rtl/sd_traffic_gen.sv
// ============================================================================
// Module      : sd_traffic_gen
// Description : Write/read/verify burst traffic generator and checker for
//               card_driver. Optional LFSR data pattern via LFSR_PATTERN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_traffic_gen
  import sd_test_pkg::*;
#(
  parameter int         ADDR_W     = 32,
  parameter int         LEN_W      = 32,
  parameter int         CNT_W      = 16,
  parameter int         NUM_BURSTS = 0,
  parameter logic [7:0] SEED       = 8'h41
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic [2:0]        LEN_SEL,
  input  logic              PATTERN_SEL,
  input  logic              DRV_BUSY,
  output logic              WR_STB,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [LEN_W-1:0]  WR_LENGTH,
  input  logic              WR_ACK,
  output logic              WD_STB,
  output logic [7:0]        WD_DATA,
  input  logic              WD_ACK,
  output logic              RD_STB,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic [LEN_W-1:0]  RD_LENGTH,
  input  logic              RD_ACK,
  input  logic              RES_STB,
  input  logic              RES_DEBUG,
  input  logic [7:0]        RES_DATA,
  output logic              RES_BUSY,
  output logic              STAT_STB,
  output logic [7:0]        STAT_DAT,
  output logic              RUNNING,
  output logic              DONE,
  output logic [CNT_W-1:0]  ERR_CNT,
  output logic [CNT_W-1:0]  BURST_CNT
);

  state_t            r_state, w_state_nxt;
  logic              r_start_d;
  logic [1:0]        r_mode;
  logic [2:0]        r_len_sel;
  logic              r_pat_sel;
  logic              r_after_wr;
  logic              r_burst_err;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic              r_done;
  logic              r_stat_stb;
  logic [7:0]        r_stat_dat;

  logic              w_start_run, w_advance, w_last;
  logic              w_wr_acc, w_rd_acc, w_chk, w_miss, w_err_evt;
  logic              w_pat_sel, w_stat_stb;
  logic [7:0]        w_stat_dat, w_exp;
  logic [31:0]       w_blen;
  logic [CNT_W:0]    w_bc_inc;
  state_t            w_first;

  assign w_blen    = burst_len(r_len_sel);
  assign w_bc_inc  = {1'b0, r_burst_cnt} + (CNT_W+1)'(1);
  assign w_last    = ((NUM_BURSTS != 0) && (w_bc_inc == (CNT_W+1)'(NUM_BURSTS))) || !START;
  assign w_first   = (r_mode == c_mode_rd) ? ST_ISSUE_RD : ST_ISSUE_WR;
  assign w_wr_acc  = (r_state == ST_ISSUE_WR) && WR_ACK;
  assign w_rd_acc  = (r_state == ST_ISSUE_RD) && RD_ACK;
  assign w_chk     = (r_state != ST_IDLE) && (r_mode != c_mode_wr) && RES_STB && !RES_DEBUG;
  assign w_miss    = w_chk && (RES_DATA != w_exp);
  assign w_err_evt = w_miss && !r_burst_err;
  // Generators reseed in IDLE, before the pattern select has been latched.
  assign w_pat_sel = (r_state == ST_IDLE) ? PATTERN_SEL : r_pat_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_start_run = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START && !r_start_d) begin
          w_start_run = 1'b1;
          w_state_nxt = (MODE == c_mode_rd) ? ST_ISSUE_RD : ST_ISSUE_WR;
        end
      end
      ST_ISSUE_WR: if (WR_ACK) w_state_nxt = ST_WAIT;
      ST_ISSUE_RD: if (RD_ACK) w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!DRV_BUSY) begin
          w_state_nxt = (r_mode == c_mode_wrv && r_after_wr) ? ST_ISSUE_RD : ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        w_advance   = 1'b1;
        w_state_nxt = w_last ? ST_DONE : w_first;
      end
      ST_DONE: if (!START) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Later assignments win: E over w/r over P/F.
  always_comb begin
    w_stat_stb = 1'b0;
    w_stat_dat = r_stat_dat;
    if (w_advance && w_last) begin
      w_stat_stb = 1'b1;
      w_stat_dat = (r_err_cnt == '0) ? c_stat_pass : c_stat_fail;
    end
    if (w_wr_acc) begin
      w_stat_stb = 1'b1;
      w_stat_dat = c_stat_wr;
    end
    if (w_rd_acc) begin
      w_stat_stb = 1'b1;
      w_stat_dat = c_stat_rd;
    end
    if (w_err_evt) begin
      w_stat_stb = 1'b1;
      w_stat_dat = c_stat_err;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_start_d   <= 1'b0;
      r_mode      <= c_mode_wr;
      r_len_sel   <= 3'd0;
      r_pat_sel   <= 1'b0;
      r_after_wr  <= 1'b0;
      r_burst_err <= 1'b0;
      r_addr      <= '0;
      r_err_cnt   <= '0;
      r_burst_cnt <= '0;
      r_done      <= 1'b0;
      r_stat_stb  <= 1'b0;
      r_stat_dat  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_start_d  <= START;
      r_stat_stb <= w_stat_stb;
      r_stat_dat <= w_stat_dat;
      if (w_start_run) begin
        r_mode      <= (MODE == c_mode_rsvd) ? c_mode_wr : MODE;
        r_len_sel   <= LEN_SEL;
        r_pat_sel   <= PATTERN_SEL;
        r_addr      <= '0;
        r_err_cnt   <= '0;
        r_burst_cnt <= '0;
        r_burst_err <= 1'b0;
        r_done      <= 1'b0;
      end
      if (w_wr_acc) r_after_wr <= 1'b1;
      if (w_rd_acc) r_after_wr <= 1'b0;
      if (w_advance) begin
        r_addr      <= r_addr + ADDR_W'(w_blen);
        r_burst_err <= 1'b0;
        if (r_burst_cnt != {CNT_W{1'b1}}) r_burst_cnt <= r_burst_cnt + CNT_W'(1);
        if (w_last) r_done <= 1'b1;
      end
      if (w_miss) begin
        r_burst_err <= 1'b1;
        if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  sd_pattern_gen #(.SEED(SEED)) u_wr_gen (
    .CLK     (CLK),
    .RST     (RST),
    .SEED_LD (w_start_run),
    .ADV     (WD_STB && WD_ACK),
    .SEL     (w_pat_sel),
    .VALUE   (WD_DATA)
  );

  sd_pattern_gen #(.SEED(SEED)) u_exp_gen (
    .CLK     (CLK),
    .RST     (RST),
    .SEED_LD (w_start_run),
    .ADV     (w_chk),
    .SEL     (w_pat_sel),
    .VALUE   (w_exp)
  );

  assign RUNNING   = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign WD_STB    = RUNNING;
  assign WR_STB    = (r_state == ST_ISSUE_WR);
  assign RD_STB    = (r_state == ST_ISSUE_RD);
  assign WR_ADDR   = r_addr;
  assign RD_ADDR   = r_addr;
  assign WR_LENGTH = WR_STB ? LEN_W'(w_blen) : '0;
  assign RD_LENGTH = RD_STB ? LEN_W'(w_blen) : '0;
  assign RES_BUSY  = DRV_BUSY;
  assign STAT_STB  = r_stat_stb;
  assign STAT_DAT  = r_stat_dat;
  assign DONE      = r_done;
  assign ERR_CNT   = r_err_cnt;
  assign BURST_CNT = r_burst_cnt;

endmodule

`default_nettype wire
